// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues icache reads, fills the IF/ID
// register and applies decode-side redirects (branch/jump/jr) and halt.
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000,
  parameter int unsigned WORD_W  = 32
) (
  input  logic              CLK,
  input  logic              RST,
  output logic [WORD_W-1:0] imemaddr,
  output logic              iREN,
  input  logic              ihit,
  input  logic [WORD_W-1:0] imemload,
  input  logic              stall,
  input  logic              redirect,
  input  logic [1:0]        pcsrc,
  input  logic [15:0]       imm16,
  input  logic [25:0]       jaddr,
  input  logic [WORD_W-1:0] rs_data,
  input  logic [WORD_W-1:0] id_npc,
  input  logic              halt,
  output logic [WORD_W-1:0] ifid_instr,
  output logic [WORD_W-1:0] ifid_npc,
  output logic              ifid_valid,
  output logic              halted
);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] instr_q, instr_d;
  logic [WORD_W-1:0] npc_q, npc_d;
  logic              valid_q, valid_d;
  logic [WORD_W-1:0] target_s;

  // Redirect target, all arithmetic wraps modulo 2^32.
  function automatic logic [WORD_W-1:0] calc_target(
    input logic [1:0]        src,
    input logic [15:0]       imm,
    input logic [25:0]       ja,
    input logic [WORD_W-1:0] rs,
    input logic [WORD_W-1:0] npc
  );
    logic [WORD_W-1:0] t;
    case (src)
      2'd1:    t = npc + {{14{imm[15]}}, imm, 2'b00};
      2'd2:    t = {npc[31:28], ja, 2'b00};
      2'd3:    t = rs;
      default: t = npc;
    endcase
    return t;
  endfunction

  assign target_s = calc_target(pcsrc, imm16, jaddr, rs_data, id_npc);

  // Next-state selection; stall outranks halt, which outranks redirect and ihit.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    npc_d   = npc_q;
    valid_d = valid_q;
    case (state_q)
      ST_RUN: begin
        if (stall) begin
          valid_d = valid_q;
        end else if (halt) begin
          valid_d = 1'b0;
          state_d = ST_HALTED;
        end else if (redirect && (pcsrc != 2'd0)) begin
          pc_d    = target_s;
          valid_d = 1'b0;
        end else if (ihit) begin
          instr_d = imemload;
          npc_d   = pc_q + 32'd4;
          valid_d = 1'b1;
          pc_d    = pc_q + 32'd4;
        end else begin
          valid_d = 1'b0;
        end
      end
      ST_HALTED: begin
        valid_d = 1'b0;
      end
      default: begin
        state_d = ST_HALTED;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and IF/ID register update with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_RUN;
      pc_q    <= PC_INIT;
      instr_q <= 32'h0000_0000;
      npc_q   <= 32'h0000_0000;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      npc_q   <= npc_d;
      valid_q <= valid_d;
    end
  end

  assign imemaddr   = pc_q;
  assign iREN       = (state_q == ST_RUN);
  assign halted     = (state_q == ST_HALTED);
  assign ifid_instr = instr_q;
  assign ifid_npc   = npc_q;
  assign ifid_valid = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized scoreboard bench for fetch_stage against a behavioural fetch model.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] imemaddr;
  logic        iREN;
  logic        ihit;
  logic [31:0] imemload;
  logic        stall;
  logic        redirect;
  logic [1:0]  pcsrc;
  logic [15:0] imm16;
  logic [25:0] jaddr;
  logic [31:0] rs_data;
  logic [31:0] id_npc;
  logic        halt;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_npc;
  logic        ifid_valid;
  logic        halted;

  fetch_stage #(.PC_INIT(32'h0000_0000), .WORD_W(32)) dut (
    .CLK(CLK), .RST(RST), .imemaddr(imemaddr), .iREN(iREN), .ihit(ihit),
    .imemload(imemload), .stall(stall), .redirect(redirect), .pcsrc(pcsrc),
    .imm16(imm16), .jaddr(jaddr), .rs_data(rs_data), .id_npc(id_npc),
    .halt(halt), .ifid_instr(ifid_instr), .ifid_npc(ifid_npc),
    .ifid_valid(ifid_valid), .halted(halted)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state
  logic [31:0] m_pc, m_instr, m_npc;
  logic        m_valid, m_halted;
  logic [63:0] sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: decode consumes IF/ID whenever it is valid and not stalled.
  always @(negedge CLK) begin
    logic [63:0] e;
    if (ifid_valid === 1'b1 && stall === 1'b0) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL sb_unexpected: got instr %h npc %h with nothing expected", ifid_instr, ifid_npc);
      end else begin
        e = sb.pop_front();
        check("sb_instr", ifid_instr, e[63:32]);
        check("sb_npc", ifid_npc, e[31:0]);
      end
    end
  end

  function automatic logic [31:0] target(input logic [1:0] src, input logic [15:0] im,
                                         input logic [25:0] ja, input logic [31:0] rs,
                                         input logic [31:0] np);
    int signed off;
    off = int'($signed(im)) * 4;
    case (src)
      2'd1:    return np + 32'(off);
      2'd2:    return (np & 32'hF000_0000) | (32'(ja) * 32'd4);
      2'd3:    return rs;
      default: return np;
    endcase
  endfunction

  // Apply one cycle of inputs and advance the model by the fetch rules.
  task automatic drive(input logic rst, input logic st, input logic rd, input logic [1:0] ps,
                       input logic [15:0] im, input logic [25:0] ja, input logic [31:0] rs,
                       input logic [31:0] np, input logic hl, input logic ih, input logic [31:0] ld);
    RST = rst; stall = st; redirect = rd; pcsrc = ps; imm16 = im; jaddr = ja;
    rs_data = rs; id_npc = np; halt = hl; ihit = ih; imemload = ld;
    if (rst) begin
      m_pc = 32'h0; m_instr = 32'h0; m_npc = 32'h0; m_valid = 1'b0; m_halted = 1'b0;
    end else if (m_halted) begin
      m_valid = 1'b0;
    end else if (st) begin
      m_valid = m_valid;
    end else if (hl) begin
      m_valid = 1'b0; m_halted = 1'b1;
    end else if (rd && ps != 2'd0) begin
      m_pc = target(ps, im, ja, rs, np); m_valid = 1'b0;
    end else if (ih) begin
      m_instr = ld; m_npc = m_pc + 32'd4; m_valid = 1'b1;
      sb.push_back({ld, m_pc + 32'd4});
      m_pc = m_pc + 32'd4;
    end else begin
      m_valid = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    if (RST) sb.delete();
    check("imemaddr", imemaddr, m_pc);
    check("iREN", 32'(iREN), 32'(!m_halted));
    check("halted", 32'(halted), 32'(m_halted));
    check("ifid_valid", 32'(ifid_valid), 32'(m_valid));
    check("ifid_instr", ifid_instr, m_instr);
    check("ifid_npc", ifid_npc, m_npc);
  endtask

  task automatic idle(input logic ih, input logic [31:0] ld);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 16'h0, 26'h0, 32'h0, 32'h0, 1'b0, ih, ld);
    tick();
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 2'd0, 16'h0, 26'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    #2;
    tick();
    check("reset_pc", imemaddr, 32'h0);
    check("reset_valid", 32'(ifid_valid), 32'h0);

    // Sequential fetch
    idle(1'b1, 32'h2000_0001);
    check("seq_npc1", ifid_npc, 32'h4);
    idle(1'b1, 32'h2000_0002);
    check("seq_npc2", ifid_npc, 32'h8);
    check("seq_pc2", imemaddr, 32'h8);

    // Three cache misses, then the hit
    for (int i = 0; i < 3; i++) begin
      idle(1'b0, 32'hDEAD_BEEF);
      check("miss_pc", imemaddr, 32'h8);
    end
    idle(1'b1, 32'h2000_0003);
    check("miss_npc", ifid_npc, 32'hC);

    // Branch back with concurrent ihit dropped
    drive(1'b0, 1'b0, 1'b1, 2'd1, 16'hFFFC, 26'h0, 32'h0, 32'h10, 1'b0, 1'b1, 32'hBAD0_0001);
    tick();
    check("branch_pc", imemaddr, 32'h0);
    check("branch_valid", 32'(ifid_valid), 32'h0);

    // Jump and jr
    drive(1'b0, 1'b0, 1'b1, 2'd2, 16'h0, 26'h000_0040, 32'h0, 32'h8000_0010, 1'b0, 1'b0, 32'h0);
    tick();
    check("jump_pc", imemaddr, 32'h8000_0100);
    drive(1'b0, 1'b0, 1'b1, 2'd3, 16'h0, 26'h0, 32'h0000_0ABC, 32'h0, 1'b0, 1'b1, 32'h0);
    tick();
    check("jr_pc", imemaddr, 32'h0000_0ABC);
    idle(1'b1, 32'h2000_0004);

    // pcsrc=0 redirect acts as no redirect
    drive(1'b0, 1'b0, 1'b1, 2'd0, 16'h0, 26'h0, 32'h1234_0000, 32'h0, 1'b0, 1'b1, 32'h2000_0005);
    tick();
    check("pcsrc0_pc", imemaddr, 32'h0000_0AC4);

    // Stall outranks everything for two cycles
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 1'b1, 2'd3, 16'h0, 26'h0, 32'h0000_5000, 32'h0, 1'b1, 1'b1, 32'hBAD0_0002);
      tick();
      check("stall_pc", imemaddr, 32'h0000_0AC4);
      check("stall_halted", 32'(halted), 32'h0);
    end
    drive(1'b0, 1'b0, 1'b0, 2'd0, 16'h0, 26'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'hBAD0_0003);
    tick();
    check("halt_halted", 32'(halted), 32'h1);
    check("halt_iren", 32'(iREN), 32'h0);
    idle(1'b1, 32'hBAD0_0004);
    check("halt_frozen_pc", imemaddr, 32'h0000_0AC4);

    // Walk to 0x40, halt, then reset out of HALTED
    drive(1'b1, 1'b0, 1'b0, 2'd0, 16'h0, 26'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    for (int i = 0; i < 16; i++) idle(1'b1, 32'h2100_0000 + 32'(i));
    check("walk_pc", imemaddr, 32'h40);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 16'h0, 26'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 2'd0, 16'h0, 26'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0);
    tick();
    check("rst_halt_pc", imemaddr, 32'h0);
    check("rst_halt_halted", 32'(halted), 32'h0);
    check("rst_halt_iren", 32'(iREN), 32'h1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic rr;
      rr = ($urandom_range(0, 199) == 0) || (m_halted && $urandom_range(0, 3) == 0);
      drive(rr, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, 2'($urandom),
            16'($urandom), 26'($urandom), $urandom, $urandom,
            $urandom_range(0, 79) == 0, $urandom_range(0, 2) != 0, $urandom);
      tick();
    end

    // Drain the scoreboard
    drive(1'b1, 1'b0, 1'b0, 2'd0, 16'h0, 26'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    for (int i = 0; i < 4; i++) idle(1'b1, 32'h2200_0000 + 32'(i));
    idle(1'b0, 32'h0);
    @(negedge CLK);
    #1;
    check("sb_drained", 32'(sb.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
